inst_issue_queue: RTL
=====================

Name: inst_issue_queue

Overview:
- Dual-wide instruction queue between the fetch stage and the dual-issue decode stage.
- Fetch pushes up to two instructions per cycle, each with its PC and 14-bit exception vector.
- The decode stage sees the two oldest entries as the first/second slots and retires 0, 1 or 2 per cycle, as chosen by the issue judge.
- Decouples fetch stalls from issue stalls.
- Flushed on branch mispredict or exception redirect.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4
- PTR_W, 4, log2(DEPTH); pointer width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard all entries (redirect)
- push_valid  in  2  bit0 = slot0 valid, bit1 = slot1 valid; bit1 without bit0 is illegal and ignored
- push_instr0, push_instr1  in  32 each  fetched instructions; slot0 is older
- push_pc0, push_pc1  in  32 each  PCs
- push_exp0, push_exp1  in  14 each  fetch-side exception vectors
- push_ready  out  1  queue can accept two entries this cycle
- pop_num  in  2  entries issued this cycle: 0, 1 or 2; 3 is treated as 2
- Instr_First, Instr_Second  out  32 each  head and head+1 instructions
- PC_First_out, PC_Second_out  out  32 each  head and head+1 PCs
- Exp_First_out, Exp_Second_out  out  14 each  head and head+1 exception vectors
- first_valid, second_valid  out  1 each  head / head+1 entry present
- occupancy  out  PTR_W+1  current entry count

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-high on rst.
- Storage: circular buffer of DEPTH entries, 78 bits each (instr, pc, exp). Registers head, tail and count (PTR_W+1 bits). Pointers wrap modulo DEPTH.
- push_ready: equals (count <= DEPTH-2), computed from the registered count only. A same-cycle pop does not raise it, so there is no combinational path from pop_num.
- Push accept: push_acc = push_ready ? (push_valid==2'b11 ? 2 : push_valid[0] ? 1 : 0) : 0.
  - Slot0 is written at tail, slot1 at tail+1.
  - tail advances by push_acc.
  - When push_ready=0, pushes are dropped; fetch must hold its data.
- Pop:
  - pop_eff = min(pop_num clamped to 2, count).
  - head advances by pop_eff.
  - Popping more than available is clamped, never underflows.
- Count update: count_next = count + push_acc - pop_eff. Simultaneous push and pop are both honoured in the same cycle.
- Read outputs: combinational from head and head+1 entries with zero added latency after write.
  - An entry written at edge N is visible at the head output in cycle N+1 if the queue was empty.
  - first_valid = (count >= 1); second_valid = (count >= 2).
  - When an output slot is invalid: Instr = 32'h0 (nop), PC = 0, Exp = 0.
- Flush (priority over push and pop in the same cycle):
  - head, tail and count go to 0 on the next edge.
  - Same-cycle push is discarded.
  - Entry RAM contents need not be cleared.
- Reset: same effect as flush. After reset:
  - first_valid = second_valid = 0
  - occupancy = 0
  - push_ready = 1
  - all data outputs = 0
- Boundaries:
  - count = DEPTH-1 or DEPTH: push_ready = 0.
  - count = DEPTH-2: a push of 2 fills the queue exactly.
  - Wrap-around with tail = DEPTH-1 and a push of 2: slot1 is written to index 0.
- No state machine beyond the pointer/count registers. All updates occur on the rising edge of clk.

Optional Feature:
- Macro: INST_ISSUE_QUEUE_PERF_EN
- Defined:
  - Adds output stall_cycles (32 bits).
  - The counter increments each cycle that push_valid[0]=1 and push_ready=0, and each cycle that first_valid=0 and flush=0. It saturates at 32'hFFFFFFFF.
  - Cleared by rst only; flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then empty reads:
  - Stimulus: assert rst one cycle, push_valid=0.
  - Response: first_valid=0, second_valid=0, Instr_First=0, occupancy=0, push_ready=1.
- Dual push then dual pop:
  - Stimulus: push 0x24010001 @PC 0xBFC00000 and 0x24020002 @0xBFC00004.
  - Next cycle: Instr_First=0x24010001, Instr_Second=0x24020002, both valid, occupancy=2.
  - Stimulus: pop_num=2. Next cycle: occupancy=0.
- Single issue with concurrent push:
  - Stimulus: occupancy=2; pop_num=1 while pushing 2.
  - Next cycle: occupancy=3. Instr_First is the former second entry.
- Full and wrap:
  - Stimulus: fill to 14 with 7 dual pushes, with no pops; then push 2.
  - Response: occupancy=16, push_ready=0. A further push is dropped and occupancy stays 16.
  - Stimulus: pop 2 per cycle and push across index 15->0.
  - Response: PC order is preserved.
- Flush priority:
  - Stimulus: occupancy=5; in one cycle assert flush, push_valid=2'b11 and pop_num=2.
  - Next cycle: occupancy=0, first_valid=0.
- Over-pop clamp and exception pass-through:
  - Stimulus: occupancy=1 with push_exp0=14'h0004; pop_num=2.
  - Before the pop: Exp_First_out=14'h0004.
  - After the pop: occupancy=0 with no underflow. A subsequent push reads back correctly.

Source files
------------

// File: rtl/inst_issue_queue.sv
// ---------------------------------------------------------------------------
// inst_issue_queue
//
// Dual-wide instruction queue that sits between fetch and dual-issue decode.
// Fetch pushes up to two instructions per cycle. Decode sees the two oldest
// entries and retires 0, 1 or 2 of them per cycle.
//
// Handshake:
//   push_ready depends only on the registered count. It is high when at least
//   two entries are free. An entry is accepted on a rising edge where
//   push_ready=1 and its push_valid bit is set. Slot1 is accepted only together
//   with slot0. While push_ready=0 fetch must hold its data.
//   pop_num has no ready: requests larger than the current count are clamped
//   to the count.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   flush                         drop all entries; wins over push and pop
//   push_valid[1:0]               slot valid bits (2'b10 is ignored)
//   push_instr0/1, push_pc0/1,
//   push_exp0/1                   pushed entry fields; slot0 is older
//   push_ready                    two free entries are available
//   pop_num[1:0]                  entries retired this cycle (3 acts as 2)
//   Instr_First/Second,
//   PC_First_out/PC_Second_out,
//   Exp_First_out/Exp_Second_out  head / head+1 fields (zero when invalid)
//   first_valid, second_valid     head / head+1 entries are present
//   occupancy                     current entry count
//   stall_cycles                  only when INST_ISSUE_QUEUE_PERF_EN is defined
//
// Optional feature macro: INST_ISSUE_QUEUE_PERF_EN adds a saturating 32-bit
// stall counter. The counter is cleared by rst only.
// ---------------------------------------------------------------------------
module inst_issue_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       push_valid,
  input  logic [31:0]      push_instr0,
  input  logic [31:0]      push_instr1,
  input  logic [31:0]      push_pc0,
  input  logic [31:0]      push_pc1,
  input  logic [13:0]      push_exp0,
  input  logic [13:0]      push_exp1,
  output logic             push_ready,
  input  logic [1:0]       pop_num,
  output logic [31:0]      Instr_First,
  output logic [31:0]      Instr_Second,
  output logic [31:0]      PC_First_out,
  output logic [31:0]      PC_Second_out,
  output logic [13:0]      Exp_First_out,
  output logic [13:0]      Exp_Second_out,
  output logic             first_valid,
  output logic             second_valid,
`ifdef INST_ISSUE_QUEUE_PERF_EN
  output logic [31:0]      stall_cycles,
`endif
  output logic [PTR_W:0]   occupancy
);

  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];
  logic [13:0] exp_mem   [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [1:0]       push_acc;
  logic [1:0]       pop_req;
  logic [1:0]       pop_eff;

  // PTR_W-bit adders wrap modulo DEPTH because DEPTH is a power of two.
  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  always_comb begin
    push_ready = (count <= READY_MAX);
    push_acc   = 2'd0;
    if (push_ready) begin
      if (push_valid == 2'b11)   push_acc = 2'd2;
      else if (push_valid[0])    push_acc = 2'd1;
    end
    pop_req = pop_num[1] ? 2'd2 : pop_num;
    // Never retire more entries than are present.
    pop_eff = (count < (PTR_W+1)'(pop_req)) ? count[1:0] : pop_req;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_eff);
      tail  <= tail + PTR_W'(push_acc);
      count <= count + (PTR_W+1)'(push_acc) - (PTR_W+1)'(pop_eff);
    end
  end

  // The entry storage has no reset. Reads are masked by the valid flags.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (push_acc != 2'd0) begin
        instr_mem[tail] <= push_instr0;
        pc_mem[tail]    <= push_pc0;
        exp_mem[tail]   <= push_exp0;
      end
      if (push_acc == 2'd2) begin
        instr_mem[tail_p1] <= push_instr1;
        pc_mem[tail_p1]    <= push_pc1;
        exp_mem[tail_p1]   <= push_exp1;
      end
    end
  end

  always_comb begin
    first_valid    = (count != '0);
    second_valid   = (count >= (PTR_W+1)'(2));
    Instr_First    = first_valid  ? instr_mem[head]    : 32'h0;
    PC_First_out   = first_valid  ? pc_mem[head]       : 32'h0;
    Exp_First_out  = first_valid  ? exp_mem[head]      : 14'h0;
    Instr_Second   = second_valid ? instr_mem[head_p1] : 32'h0;
    PC_Second_out  = second_valid ? pc_mem[head_p1]    : 32'h0;
    Exp_Second_out = second_valid ? exp_mem[head_p1]   : 14'h0;
    occupancy      = count;
  end

`ifdef INST_ISSUE_QUEUE_PERF_EN
  logic stall_inc;
  // Fetch blocked by a full queue, or decode starved by an empty queue.
  assign stall_inc = (push_valid[0] && !push_ready) || (!first_valid && !flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'h0;
    end else if (stall_inc && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'h1;
    end
  end
`endif

endmodule
